// File: rtl/noc_inject_buffer.sv
//==============================================================================
// Module      : noc_inject_buffer
// Description : PE-to-router injection FIFO with destination filtering and
//               forwarded/dropped flit counters. Define NOC_INJECT_STATS_EN to
//               build the stall_cycles / max_fill statistics registers.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module noc_inject_buffer #(
  parameter int X           = 2,
  parameter int Y           = 2,
  parameter int data_width  = 256,
  parameter int x_size      = 1,
  parameter int y_size      = 1,
  parameter int total_width = x_size + y_size + data_width,
  parameter int DEPTH       = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_valid,
  input  logic [total_width-1:0]     i_data,
  output logic                       o_ready,
  output logic                       o_valid,
  output logic [total_width-1:0]     o_data,
  input  logic                       i_ready,
  output logic [$clog2(DEPTH):0]     fill_level,
  output logic [31:0]                sent_count,
  output logic [31:0]                drop_count,
  output logic                       dest_err,
  output logic [31:0]                stall_cycles,
  output logic [$clog2(DEPTH):0]     max_fill
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;

  logic [total_width-1:0] mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;

  logic [x_size-1:0]      dest_x;
  logic [y_size-1:0]      dest_y;
  logic                   dest_bad;
  logic                   accept;
  logic                   wr_en;
  logic                   drop_en;
  logic                   rd_en;
  logic                   is_empty;
  logic                   is_full;

  // Extra pointer MSB separates full (MSBs differ) from empty (MSBs equal).
  assign is_empty   = (wr_ptr == rd_ptr);
  assign is_full    = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                      (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign fill_level = wr_ptr - rd_ptr;

  assign o_ready = !is_full;
  assign o_valid = !is_empty;
  assign o_data  = is_empty ? '0 : mem[rd_ptr[ADDR_W-1:0]];

  assign dest_x   = i_data[x_size-1:0];
  assign dest_y   = i_data[x_size+y_size-1:x_size];
  assign dest_bad = (32'(dest_x) >= 32'(X)) || (32'(dest_y) >= 32'(Y));

  assign accept  = i_valid && o_ready;
  assign wr_en   = accept && !dest_bad;
  assign drop_en = accept && dest_bad;
  assign rd_en   = o_valid && i_ready;

  // Storage carries no reset; o_data is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[ADDR_W-1:0]] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sent_count <= '0;
      drop_count <= '0;
      dest_err   <= 1'b0;
    end else begin
      if (rd_en && (sent_count != 32'hFFFF_FFFF)) begin
        sent_count <= sent_count + 32'd1;
      end
      if (drop_en && (drop_count != 32'hFFFF_FFFF)) begin
        drop_count <= drop_count + 32'd1;
      end
      if (drop_en) begin
        dest_err <= 1'b1;
      end
    end
  end

`ifdef NOC_INJECT_STATS_EN
  logic [PTR_W-1:0] fill_next;
  logic [31:0]      stall_q;
  logic [PTR_W-1:0] max_q;

  // Track the post-edge occupancy so max_fill never lags fill_level.
  always_comb begin
    fill_next = fill_level;
    if (wr_en && !rd_en) begin
      fill_next = fill_level + 1'b1;
    end else if (!wr_en && rd_en) begin
      fill_next = fill_level - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      max_q   <= '0;
    end else begin
      if (o_valid && !i_ready && (stall_q != 32'hFFFF_FFFF)) begin
        stall_q <= stall_q + 32'd1;
      end
      if (fill_next > max_q) begin
        max_q <= fill_next;
      end
    end
  end

  assign stall_cycles = stall_q;
  assign max_fill     = max_q;
`else
  assign stall_cycles = '0;
  assign max_fill     = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_noc_inject_buffer.sv
//==============================================================================
// Module      : tb_noc_inject_buffer
// Description : Randomised self-checking bench for noc_inject_buffer using a
//               queue-based reference model. Honours NOC_INJECT_STATS_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_noc_inject_buffer;

  localparam int MX    = 2;
  localparam int MY    = 2;
  localparam int DW    = 32;
  localparam int XS    = 2;
  localparam int YS    = 2;
  localparam int TW    = XS + YS + DW;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst;
  logic          i_valid;
  logic [TW-1:0] i_data;
  logic          o_ready;
  logic          o_valid;
  logic [TW-1:0] o_data;
  logic          i_ready;
  logic [2:0]    fill_level;
  logic [31:0]   sent_count;
  logic [31:0]   drop_count;
  logic          dest_err;
  logic [31:0]   stall_cycles;
  logic [2:0]    max_fill;

  noc_inject_buffer #(
    .X(MX), .Y(MY), .data_width(DW), .x_size(XS), .y_size(YS), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_data(i_data), .o_ready(o_ready),
    .o_valid(o_valid), .o_data(o_data), .i_ready(i_ready),
    .fill_level(fill_level), .sent_count(sent_count), .drop_count(drop_count),
    .dest_err(dest_err), .stall_cycles(stall_cycles), .max_fill(max_fill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;

  // Reference model: a bounded queue plus plain counters.
  logic [TW-1:0] q[$];
  longint        m_sent;
  longint        m_drop;
  logic          m_err;
  longint        m_stall;
  int            m_max;
  bit            m_acc;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_sent  = 0;
    m_drop  = 0;
    m_err   = 1'b0;
    m_stall = 0;
    m_max   = 0;
  endtask

  function automatic longint sat(input longint v);
    return (v > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v;
  endfunction

  task automatic model_edge(input logic v, input logic [TW-1:0] d, input logic r);
    bit bad;
    m_acc = v && (q.size() < DEPTH);
    bad   = (int'(d[XS-1:0]) >= MX) || (int'(d[XS+YS-1:XS]) >= MY);
    if (q.size() > 0 && !r) m_stall = sat(m_stall + 1);
    if (q.size() > 0 && r) begin
      void'(q.pop_front());
      m_sent = sat(m_sent + 1);
    end
    if (m_acc && bad) begin
      m_drop = sat(m_drop + 1);
      m_err  = 1'b1;
    end else if (m_acc) begin
      q.push_back(d);
    end
    if (q.size() > m_max) m_max = q.size();
  endtask

  task automatic check_outputs();
    chk("o_valid", 64'(o_valid), 64'(q.size() != 0));
    chk("o_data", 64'(o_data), (q.size() != 0) ? 64'(q[0]) : 64'd0);
    chk("o_ready", 64'(o_ready), 64'(q.size() != DEPTH));
    chk("fill_level", 64'(fill_level), 64'(q.size()));
  endtask

  task automatic check_all();
    check_outputs();
    chk("sent_count", 64'(sent_count), 64'(m_sent));
    chk("drop_count", 64'(drop_count), 64'(m_drop));
    chk("dest_err", 64'(dest_err), 64'(m_err));
`ifdef NOC_INJECT_STATS_EN
    chk("stall_cycles", 64'(stall_cycles), 64'(m_stall));
    chk("max_fill", 64'(max_fill), 64'(m_max));
`else
    chk("stall_cycles", 64'(stall_cycles), 64'd0);
    chk("max_fill", 64'(max_fill), 64'd0);
`endif
  endtask

  // Drive one cycle; outputs are checked before the edge (must ignore the
  // new inputs) and again just after it.
  task automatic step(input logic v, input logic [TW-1:0] d, input logic r);
    i_valid = v;
    i_data  = d;
    i_ready = r;
    #1;
    check_outputs();
    @(posedge clk);
    model_edge(v, d, r);
    #1;
    check_all();
  endtask

  task automatic push_flit(input logic [TW-1:0] d, input logic r);
    int tries;
    tries = 0;
    m_acc = 1'b0;
    while (!m_acc && tries < 20) begin
      step(1'b1, d, r);
      tries++;
    end
    if (!m_acc) chk("push_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_reset();
    i_valid = 1'b0;
    i_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    chk("o_ready_after_rst", 64'(o_ready), 64'd1);
    check_all();
  endtask

  function automatic logic [TW-1:0] flit(input logic [DW-1:0] p, input int x, input int y);
    logic [TW-1:0] f;
    f = {p, YS'(y), XS'(x)};
    return f;
  endfunction

  function automatic logic [TW-1:0] rand_flit();
    int x;
    int y;
    x = $urandom_range(0, 1);
    y = $urandom_range(0, 1);
    if ($urandom_range(0, 7) == 0) x = $urandom_range(2, 3);
    if ($urandom_range(0, 9) == 0) y = $urandom_range(2, 3);
    return flit(DW'($urandom), x, y);
  endfunction

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    rst     = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_data  = '0;
    model_reset();
    #12;
    check_all();
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    chk("o_ready_after_rst", 64'(o_ready), 64'd1);

    // Latency: flit visible one cycle after write, counted one cycle later.
    step(1'b1, flit(32'hA5, 1, 1), 1'b1);
    chk("lat_payload", 64'(o_data[TW-1:XS+YS]), 64'hA5);
    step(1'b0, '0, 1'b1);
    chk("lat_sent", 64'(sent_count), 64'd1);

    // Full / back-pressure: fifth flit is held until space opens.
    do_reset();
    for (int i = 1; i <= 4; i++) push_flit(flit(DW'(i), i % 2, 0), 1'b0);
    chk("full_ready", 64'(o_ready), 64'd0);
    for (int i = 0; i < 3; i++) step(1'b1, flit(32'd5, 1, 1), 1'b0);
    chk("full_fill", 64'(fill_level), 64'd4);
    push_flit(flit(32'd5, 1, 1), 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);
    chk("full_sent", 64'(sent_count), 64'd5);

    // Simultaneous push/pop at occupancy 2.
    do_reset();
    push_flit(flit(32'h100, 0, 0), 1'b0);
    push_flit(flit(32'h101, 0, 1), 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, flit(DW'(32'h200 + i), 1, 0), 1'b1);
    chk("pp_fill", 64'(fill_level), 64'd2);
    chk("pp_sent", 64'(sent_count), 64'd10);

    // Bad destination, then a good flit; dest_err stays set.
    do_reset();
    step(1'b1, flit(32'hBAD, 3, 0), 1'b1);
    step(1'b1, flit(32'h600D, 1, 0), 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("bad_drop", 64'(drop_count), 64'd1);
    chk("bad_sent", 64'(sent_count), 64'd1);
    chk("bad_sticky", 64'(dest_err), 64'd1);

    // Stats: three flits queued, router stalled seven cycles.
    do_reset();
    for (int i = 0; i < 3; i++) push_flit(flit(DW'(i), 0, 1), 1'b1 == 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b0);
`ifdef NOC_INJECT_STATS_EN
    chk("stats_max", 64'(max_fill), 64'd3);
`else
    chk("stats_stall_off", 64'(stall_cycles), 64'd0);
    chk("stats_max_off", 64'(max_fill), 64'd0);
`endif

    // Randomised traffic with occasional mid-traffic resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      else step(1'(($urandom_range(0, 9) < 7)), rand_flit(),
                1'(($urandom_range(0, 9) < 5)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
